// File: rtl/led_pwm_pio.sv
// Avalon-MM LED peripheral: on/off data, set/clear, per-channel PWM duty and an optional blink engine.
// Blink engine, BLINK_MASK and BLINK_PERIOD exist only when LED_PWM_BLINK_EN is defined.
module led_pwm_pio #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [5:0]          avs_address,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  output logic [NUM_LEDS-1:0] leds_export
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     presc;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] data;
  logic [PWM_BITS-1:0] duty [NUM_LEDS];
  logic [NUM_LEDS-1:0] blink_mask;
  logic                blink_phase;
  logic [31:0]         rd_mux;
  logic [NUM_LEDS-1:0] led_next;
  logic                unused;

  // Upper write-data bits are intentionally dropped; register widths are narrower than the bus.
  assign unused = ^avs_writedata;
  assign tick   = (presc == PS_LAST);

`ifdef LED_PWM_BLINK_EN
  logic [15:0] blink_period;
  logic [15:0] blink_cnt;
  logic        frame_end;

  assign frame_end = tick && (&pwm_cnt);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      blink_mask   <= '0;
      blink_period <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
    end else begin
      if (avs_write && avs_address == 6'd3)
        blink_mask <= avs_writedata[NUM_LEDS-1:0];
      // A period write restarts the blink cycle so software sees a clean first half-period.
      if (avs_write && avs_address == 6'd4) begin
        blink_period <= avs_writedata[15:0];
        blink_cnt    <= '0;
        blink_phase  <= 1'b0;
      end else if (blink_period == 16'd0) begin
        blink_cnt    <= '0;
        blink_phase  <= 1'b0;
      end else if (frame_end) begin
        if (blink_cnt == blink_period - 16'd1) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign blink_mask  = '0;
  assign blink_phase = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      6'd0: rd_mux = 32'(data);
`ifdef LED_PWM_BLINK_EN
      6'd3: rd_mux = 32'(blink_mask);
      6'd4: rd_mux = 32'(blink_period);
`endif
      default: begin
        for (int i = 0; i < NUM_LEDS; i++)
          if (avs_address == 6'(32 + i)) rd_mux = 32'(duty[i]);
      end
    endcase
  end

  // All-ones duty means fully on, so the compare alone would lose one count per frame.
  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      led_next[i] = data[i] && ((&duty[i]) || (pwm_cnt < duty[i]))
                    && !(blink_mask[i] && blink_phase);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      presc        <= '0;
      pwm_cnt      <= '0;
      data         <= '0;
      avs_readdata <= '0;
      leds_export  <= '0;
      for (int i = 0; i < NUM_LEDS; i++) duty[i] <= '1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (avs_read) avs_readdata <= rd_mux;
      if (avs_write) begin
        case (avs_address)
          6'd0:    data <= avs_writedata[NUM_LEDS-1:0];
          6'd1:    data <= data | avs_writedata[NUM_LEDS-1:0];
          6'd2:    data <= data & ~avs_writedata[NUM_LEDS-1:0];
          default: ;
        endcase
        for (int i = 0; i < NUM_LEDS; i++)
          if (avs_address == 6'(32 + i)) duty[i] <= avs_writedata[PWM_BITS-1:0];
      end
      leds_export <= led_next;
    end
  end

endmodule

// File: tb/tb_led_pwm_pio.sv
// Self-checking bench for led_pwm_pio: expectations queue up with stimulus and are compared when results arrive.
// Blink checks adapt to whether LED_PWM_BLINK_EN is defined.
module tb_led_pwm_pio;
  localparam int NL = 8;
  localparam int PB = 8;
  localparam int PS = 1;
  localparam int FRAME = PS * (1 << PB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    avs_address = '0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic          avs_read = 1'b0;
  logic [31:0]   avs_readdata;
  logic [NL-1:0] leds;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  string       nm_q  [$];

  always #5 clk = ~clk;

  led_pwm_pio #(.NUM_LEDS(NL), .PWM_BITS(PB), .PRESCALE(PS)) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .avs_address  (avs_address),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_read     (avs_read),
    .avs_readdata (avs_readdata),
    .leds_export  (leds)
  );

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    got_q.push_back(avs_readdata);
  endtask

  task automatic expect_rd(input string nm, input logic [5:0] a, input logic [31:0] e);
    exp_q.push_back(e); nm_q.push_back(nm);
    rd(a);
  endtask

  task automatic measure_high(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) begin
      c += int'(leds[0]);
      @(negedge clk);
    end
    got_q.push_back(32'(c));
  endtask

  task automatic test_reset;
    logic [31:0] e, g; string nm;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (leds !== '0) begin errors++; $display("FAIL reset_leds: got 0x%0h expected 0x0", leds); end
    checks++;
    if (avs_readdata !== '0) begin errors++; $display("FAIL reset_readdata: got 0x%0h expected 0x0", avs_readdata); end
    expect_rd("reset_data", 6'd0, 32'h0);
    expect_rd("reset_mask", 6'd3, 32'h0);
    expect_rd("reset_period", 6'd4, 32'h0);
    expect_rd("reset_duty0", 6'd32, 32'hFF);
    expect_rd("reset_duty7", 6'd39, 32'hFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e); end
    end
  endtask

  task automatic test_data;
    logic [31:0] e, g; string nm;
    wr(6'd0, 32'hA5);
    checks++;
    if (leds !== 8'h00) begin errors++; $display("FAIL data_one_edge: got 0x%0h expected 0x0", leds); end
    @(negedge clk);
    checks++;
    if (leds !== 8'hA5) begin errors++; $display("FAIL data_two_edges: got 0x%0h expected 0xa5", leds); end
    expect_rd("data_rb", 6'd0, 32'h0000_00A5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e); end
    end
  endtask

  task automatic test_access;
    logic [31:0] e, g; string nm;
    wr(6'd0, 32'hFFFF_FFFF);
    expect_rd("data_wide", 6'd0, 32'h0000_00FF);
    expect_rd("unmapped_40", 6'd40, 32'h0);
    wr(6'd40, 32'hFFFF_FFFF);
    expect_rd("unmapped_40_wr", 6'd40, 32'h0);
    expect_rd("unmapped_5", 6'd5, 32'h0);
    expect_rd("duty31_absent", 6'd63, 32'h0);
    wr(6'd32, 32'hFFFF_FF40);
    expect_rd("duty0_wide", 6'd32, 32'h40);
    wr(6'd32, 32'hFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e); end
    end
  endtask

  task automatic test_set_clear;
    logic [31:0] e, g; string nm;
    wr(6'd0, 32'hF0);
    wr(6'd1, 32'h03);
    expect_rd("after_set", 6'd0, 32'hF3);
    wr(6'd2, 32'h30);
    expect_rd("after_clear", 6'd0, 32'hC3);
    expect_rd("set_reads0", 6'd1, 32'h0);
    expect_rd("clear_reads0", 6'd2, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e, g; string nm;
    exp_q.push_back(32'hC3); nm_q.push_back("rw_same_cycle_old");
    avs_address = 6'd0; avs_writedata = 32'h3C; avs_write = 1'b1; avs_read = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; avs_read = 1'b0;
    got_q.push_back(avs_readdata);
    expect_rd("rw_same_cycle_new", 6'd0, 32'h3C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e); end
    end
  endtask

  task automatic test_pwm;
    logic [31:0] e, g; string nm;
    int duties [5] = '{64, 0, 1, 254, 255};
    wr(6'd0, 32'h01);
    foreach (duties[k]) begin
      wr(6'd32, 32'(duties[k]));
      @(negedge clk);
      e = (duties[k] == (1 << PB) - 1) ? 32'(FRAME) : 32'(PS * duties[k]);
      for (int w = 0; w < 2; w++) begin
        exp_q.push_back(e); nm_q.push_back($sformatf("pwm_duty%0d_win%0d", duties[k], w));
        measure_high(FRAME);
      end
    end
    wr(6'd32, 32'hFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", nm, g, e); end
    end
  endtask

  task automatic test_blink;
    logic [31:0] e, g; string nm;
`ifdef LED_PWM_BLINK_EN
    bit found = 0;
    logic prev;
    int n;
    wr(6'd0, 32'h01);
    wr(6'd3, 32'h01);
    expect_rd("mask_rb", 6'd3, 32'h01);
    wr(6'd4, 32'h2);
    expect_rd("period_rb", 6'd4, 32'h2);
    prev = leds[0];
    for (int k = 0; k < 6 * FRAME && !found; k++) begin
      @(negedge clk);
      if (prev && !leds[0]) found = 1;
      prev = leds[0];
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL blink_edge: no falling edge within %0d cycles, required one", 6 * FRAME);
    end else begin
      exp_q.push_back(32'(2 * FRAME)); nm_q.push_back("blink_off_len");
      n = 0;
      while (!leds[0] && n < 8 * FRAME) begin n++; @(negedge clk); end
      got_q.push_back(32'(n));
      exp_q.push_back(32'(2 * FRAME)); nm_q.push_back("blink_on_len");
      n = 0;
      while (leds[0] && n < 8 * FRAME) begin n++; @(negedge clk); end
      got_q.push_back(32'(n));
    end
    wr(6'd4, 32'h0);
    @(negedge clk);
    exp_q.push_back(32'(3 * FRAME)); nm_q.push_back("blink_period0_steady");
    measure_high(3 * FRAME);
    wr(6'd4, 32'h2);
`else
    wr(6'd3, 32'hFF);
    wr(6'd4, 32'h5);
    expect_rd("mask_absent", 6'd3, 32'h0);
    expect_rd("period_absent", 6'd4, 32'h0);
    wr(6'd0, 32'h01);
    @(negedge clk);
    exp_q.push_back(32'(3 * FRAME)); nm_q.push_back("no_blink_steady");
    measure_high(3 * FRAME);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", nm, g, e); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] e, g; string nm;
    wr(6'd0, 32'hFF);
    wr(6'd33, 32'h10);
    repeat (FRAME + 37) @(negedge clk);
    checks++;
    if (leds === '0) begin errors++; $display("FAIL pre_reset_lit: got 0x%0h expected nonzero", leds); end
    rd(6'd0);
    void'(got_q.pop_front());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (leds !== '0) begin errors++; $display("FAIL midreset_leds: got 0x%0h expected 0x0", leds); end
    checks++;
    if (avs_readdata !== '0) begin errors++; $display("FAIL midreset_readdata: got 0x%0h expected 0x0", avs_readdata); end
    @(negedge clk);
    checks++;
    if (leds !== '0) begin errors++; $display("FAIL midreset_leds_next: got 0x%0h expected 0x0", leds); end
    expect_rd("midreset_data", 6'd0, 32'h0);
    expect_rd("midreset_mask", 6'd3, 32'h0);
    expect_rd("midreset_period", 6'd4, 32'h0);
    expect_rd("midreset_duty0", 6'd32, 32'hFF);
    expect_rd("midreset_duty1", 6'd33, 32'hFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e); end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_data();
    test_access();
    test_set_clear();
    test_back_to_back();
    test_pwm();
    test_blink();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pwm_pio.md
# led_pwm_pio

Parametrised LED output peripheral for the NIOS2 Qsys system. It is an Avalon-MM slave that drives `leds_export` and succeeds the fixed 8-bit LED PIO. It keeps the legacy on/off data register and adds:
- a configurable channel count
- per-channel PWM brightness
- atomic set/clear registers
- a hardware blink engine

## Interface
Parameters:
- `NUM_LEDS`, default 8: number of LED channels, 1..32.
- `PWM_BITS`, default 8: duty/PWM counter width, 2..16.
- `PRESCALE`, default 50: clock cycles per PWM tick, ≥1.

Ports:
- `clk_clk` in 1: system clock; single clock domain.
- `reset_reset` in 1: reset, synchronous, active-high.
- `avs_address` in 6: word address.
- `avs_write` in 1: write strobe.
- `avs_writedata` in 32: write data.
- `avs_read` in 1: read strobe.
- `avs_readdata` out 32: read data, fixed read latency 1.
- `leds_export` out `NUM_LEDS`: registered LED drive, active-high.

## Operation
Register map (word addresses):
- 0 DATA: on/off enable bits, R/W.
- 1 SET: write-1-to-set DATA bits; reads 0.
- 2 CLEAR: write-1-to-clear DATA bits; reads 0.
- 3 BLINK_MASK: channels subject to blink, R/W.
- 4 BLINK_PERIOD: 16-bit half-period in PWM frames, R/W.
- 32+i DUTY[i]: `PWM_BITS`-bit duty for channel i, R/W.

Register access rules:
- Bits above `NUM_LEDS` (or above `PWM_BITS` for DUTY) are ignored on write and read as 0.
- Unmapped addresses, including DUTY[i] with i ≥ `NUM_LEDS`, read 0; writes to them are ignored.

Prescaler and PWM counter:
- The prescaler counts 0..`PRESCALE`-1 and pulses `tick` on its terminal count.
- `pwm_cnt` (`PWM_BITS` wide) increments on `tick` and wraps from all-ones to 0.
- The wrap asserts `frame_end` for one cycle.

Blink engine:
- `blink_cnt` (16 bits) increments on each `frame_end`.
- When `blink_cnt` = BLINK_PERIOD-1 at `frame_end`, `blink_cnt` clears to 0 and `blink_phase` toggles.
- BLINK_PERIOD = 0 forces `blink_phase` = 0 and `blink_cnt` = 0.
- Any write to BLINK_PERIOD clears `blink_cnt` and `blink_phase` on the same edge.

Channel i output (next `leds_export[i]`) is:
- DATA[i] AND (DUTY[i] all-ones OR `pwm_cnt` < DUTY[i]) AND NOT (BLINK_MASK[i] AND `blink_phase`).
- DUTY = 0 means the channel is always off.

Reset values:
- DATA, BLINK_MASK, BLINK_PERIOD: 0.
- DUTY[i]: all-ones, so legacy DATA-only software sees full brightness.
- All counters and `blink_phase`: 0.
- `leds_export` and `avs_readdata`: 0.

Reset asserted mid-frame or mid-blink:
- All state returns to reset values on the next edge.
- `leds_export` is 0 on the cycle after that edge.

## Timing
- Write: the register updates on the edge where `avs_write` is sampled.
- `leds_export` reflects the new register value one edge later (2 edges after the write).
- Read: `avs_readdata` is valid on the cycle after `avs_read`.
- `avs_readdata` holds its value until the next read; it is 0 after reset.
- A read and a write to the same address in the same cycle returns the old value.
- PWM frame length = `PRESCALE` × 2^`PWM_BITS` cycles.
- Blink half-period = BLINK_PERIOD frames.
- No wait states: `avs_waitrequest` is not present.

## Configuration
- `LED_PWM_BLINK_EN` defined: blink engine, BLINK_MASK and BLINK_PERIOD present as specified.
- Macro not defined:
  - The blink logic is removed.
  - Addresses 3 and 4 read 0 and ignore writes.
  - `blink_phase` is constant 0.
  - The remaining behaviour is identical.

## Test plan
- Reset, then write DATA=0xA5 with DUTY at its reset value → `leds_export`=0xA5 two edges after the write; readback of address 0 = 0x000000A5.
- `PRESCALE`=1, `PWM_BITS`=8, DATA=0x01, DUTY[0]=64 → `leds_export[0]` high for exactly 64 of every 256 cycles; DUTY[0]=0 → constantly low.
- DATA=0xF0, write SET=0x03, then CLEAR=0x30 → DATA readback 0xF3, then 0xC3; SET/CLEAR read 0.
- `PRESCALE`=1, `PWM_BITS`=2, BLINK_MASK=0x01, BLINK_PERIOD=2, DATA=0x01 → `leds_export[0]` alternates 8 cycles on, 8 cycles off; writing BLINK_PERIOD=0 → steady on.
- Read address 40 with `NUM_LEDS`=8, and write 0xFFFFFFFF to DATA → read returns 0; DATA reads 0x000000FF.
- Assert `reset_reset` for one cycle mid-blink with LEDs lit → `leds_export`=0 and all registers at reset values the cycle after the reset edge.
